arcade_input_cond: RTL

- Conditions the merged player controls (keyboard, USB and DB9/DB15 sources) before they reach the galaga core's coin/start/left/right/fire inputs.
- Synchronises and debounces every control bit.
- Shapes coin presses into fixed-width, rate-limited credit pulses.
- Queues coin presses that arrive while a pulse or its gap is in progress.
- Runs on the core clock, directly upstream of the game core.

---
 rtl/arcade_input_pkg.sv | 28 ++
 rtl/input_debounce.sv | 60 ++++++
 rtl/arcade_input_cond.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input conditioner.
//   - Bit positions of each control inside in_raw / btn_out.
//   - Coin shaper state encoding.
//   - Depth limit of the coin press queue.
package arcade_input_pkg;

  localparam int N_INPUTS    = 10;
  localparam int IDX_LEFT1   = 0;
  localparam int IDX_RIGHT1  = 1;
  localparam int IDX_FIRE1   = 2;
  localparam int IDX_START1  = 3;
  localparam int IDX_LEFT2   = 4;
  localparam int IDX_RIGHT2  = 5;
  localparam int IDX_FIRE2   = 6;
  localparam int IDX_START2  = 7;
  localparam int IDX_COIN    = 8;
  localparam int IDX_SERVICE = 9;

  // Largest number of coin presses remembered while a credit is in progress.
  localparam logic [1:0] PEND_MAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_e;

endpackage

// File: rtl/input_debounce.sv
// Single-bit two-flop synchroniser followed by a debouncer.
// The debounced level only follows the synchronised input once the input
// has disagreed with it for DEB_CYCLES consecutive cycles.
// Ports:
//   clk_sys - core clock
//   reset   - synchronous, active-high
//   din     - raw asynchronous input
//   dout    - debounced level
module input_debounce
  import arcade_input_pkg::*;
#(
  parameter int DEB_CYCLES = 18000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This is the DEB_CYCLES-th consecutive disagreeing sample.
      state_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = state_q;

endmodule

// File: rtl/arcade_input_cond.sv
// Conditions the merged player controls ahead of the game core.
// Every bit is synchronised and debounced; the coin bit is turned into
// fixed-width credit pulses separated by a fixed gap, with up to three
// presses queued while a credit is being issued.
// Optional build macro ARCADE_INPUT_AUTOFIRE_EN adds the autofire input,
// which makes held fire buttons toggle every AF_HALF cycles.
// Ports:
//   clk_sys   - core clock
//   reset     - synchronous, active-high
//   in_raw    - raw active-high controls (bit map in arcade_input_pkg)
//   btn_out   - conditioned controls, bit 8 is the shaped coin pulse
//   coin_busy - credit pulse or its trailing gap in progress
//   coin_pend - presses queued but not yet issued
//   autofire  - autofire enable (only with ARCADE_INPUT_AUTOFIRE_EN)
module arcade_input_cond
  import arcade_input_pkg::*;
#(
  parameter int DEB_CYCLES = 18000,
  parameter int COIN_PULSE = 1800000,
  parameter int COIN_GAP   = 1800000
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  , parameter int AF_HALF  = 900000
`endif
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] in_raw,
  output logic [N_INPUTS-1:0] btn_out,
  output logic                coin_busy,
  output logic [1:0]          coin_pend
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  , input  logic              autofire
`endif
);

  localparam int CNT_MAX = (COIN_PULSE > COIN_GAP) ? COIN_PULSE : COIN_GAP;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] PULSE_LAST = CW'(COIN_PULSE - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(COIN_GAP - 1);

  logic [N_INPUTS-1:0] deb;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_deb
      input_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
        .clk_sys(clk_sys),
        .reset  (reset),
        .din    (in_raw[gi]),
        .dout   (deb[gi])
      );
    end
  endgenerate

`ifdef ARCADE_INPUT_AUTOFIRE_EN
  localparam int AW = (AF_HALF > 1) ? $clog2(AF_HALF) : 1;
  localparam logic [AW-1:0] AF_LAST = AW'(AF_HALF - 1);

  // af_gate high means the fire output is in its forced-low half period.
  logic [1:0] af_gate;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_af
      localparam int FI = (gi == 0) ? IDX_FIRE1 : IDX_FIRE2;
      logic          phase_q, phase_d;
      logic [AW-1:0] cnt_q, cnt_d;

      always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (!deb[FI]) begin
          // Released: restart so the next press begins with a high phase.
          phase_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == AF_LAST) begin
          phase_d = ~phase_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk_sys) begin
        if (reset) begin
          phase_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          phase_q <= phase_d;
          cnt_q   <= cnt_d;
        end
      end

      assign af_gate[gi] = phase_q;
    end
  endgenerate
`endif

  coin_state_e         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          pend_q, pend_d;
  logic                coin_prev_q, coin_prev_d;
  logic [N_INPUTS-1:0] btn_q, btn_d;
  logic                busy_q, busy_d;
  logic                press;

  always_comb begin
    coin_prev_d = deb[IDX_COIN];
    press       = deb[IDX_COIN] & ~coin_prev_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;

    case (state_q)
      IDLE: begin
        if (press || (pend_q != 2'd0)) begin
          state_d = PULSE;
          cnt_d   = PULSE_LAST;
          // A fresh press in the same cycle takes the queued slot's place,
          // so the queue only shrinks when the credit comes from it alone.
          if ((pend_q != 2'd0) && !press) begin
            pend_d = pend_q - 2'd1;
          end
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (press && (pend_q != PEND_MAX)) begin
          pend_d = pend_q + 2'd1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (press && (pend_q != PEND_MAX)) begin
          pend_d = pend_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    btn_d           = deb;
    btn_d[IDX_COIN] = (state_d == PULSE);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    btn_d[IDX_FIRE1] = deb[IDX_FIRE1] & ~(autofire & af_gate[0]);
    btn_d[IDX_FIRE2] = deb[IDX_FIRE2] & ~(autofire & af_gate[1]);
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 2'd0;
      coin_prev_q <= 1'b0;
      btn_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      coin_prev_q <= coin_prev_d;
      btn_q       <= btn_d;
      busy_q      <= busy_d;
    end
  end

  assign btn_out   = btn_q;
  assign coin_busy = busy_q;
  assign coin_pend = pend_q;

endmodule
